// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage has priority, and the loader/debug port
// is forced through after STARVE_MAX consecutive losses, stalling the pipeline for that cycle.
module dmem_arbiter #(
  parameter int SIZE       = 1024,
  parameter int STARVE_MAX = 4,
  parameter int WORD       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_read,
  input  logic            p_write,
  input  logic [WORD-1:0] p_addr,
  input  logic [WORD-1:0] p_wdata,
  output logic [WORD-1:0] p_rdata,
  output logic            p_stall,
  input  logic            l_req,
  input  logic            l_we,
  input  logic [WORD-1:0] l_addr,
  input  logic [WORD-1:0] l_wdata,
  output logic            l_ack,
  output logic            l_err,
  output logic [WORD-1:0] l_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_e;

  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [WORD-3:0] SIZE_W     = (WORD-2)'(SIZE);

  state_e          state_q, state_d;
  logic [3:0]      starve_q, starve_d;
  logic            l_ack_q, l_ack_d;
  logic            l_err_q, l_err_d;
  logic [WORD-1:0] l_rdata_q, l_rdata_d;

  logic p_act, l_elig, l_oor, l_win;

  assign p_act  = p_read | p_write;
  assign l_elig = l_req & (state_q == IDLE);
  assign l_oor  = (l_addr[WORD-1:2] >= SIZE_W);
  assign l_win  = l_elig & (~p_act | (starve_q == STARVE_LIM));

  assign p_rdata = mem_rdata;
  assign l_ack   = l_ack_q;
  assign l_err   = l_err_q;
  assign l_rdata = l_rdata_q;

  // Memory port mux; strobes and stall are held off while reset is asserted
  always_comb begin
    mem_addr  = p_addr;
    mem_wdata = p_wdata;
    mem_read  = p_read;
    mem_write = p_write;
    p_stall   = 1'b0;
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      p_stall   = 1'b0;
    end else if (l_win) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_read  = ~l_we & ~l_oor;
      mem_write = l_we & ~l_oor;
      p_stall   = p_act;
    end else begin
      mem_read  = p_read;
      mem_write = p_write;
      p_stall   = 1'b0;
    end
  end

  // Next-state for the ack FSM, loader response registers and starvation counter
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    l_ack_d   = 1'b0;
    l_err_d   = 1'b0;
    l_rdata_d = l_rdata_q;
    case (state_q)
      IDLE: begin
        if (l_win) begin
          state_d   = ACK;
          l_ack_d   = 1'b1;
          l_err_d   = l_oor;
          l_rdata_d = (l_we | l_oor) ? {WORD{1'b0}} : mem_rdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // In IDLE, a pending request that did not win has just lost to the pipeline
    if (state_q == ACK) begin
      starve_d = starve_q;
    end else if (l_win || !l_req) begin
      starve_d = 4'd0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      l_ack_q   <= 1'b0;
      l_err_q   <= 1'b0;
      l_rdata_q <= {WORD{1'b0}};
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      l_ack_q   <= l_ack_d;
      l_err_q   <= l_err_d;
      l_rdata_q <= l_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle vector table plus hand-written
// sequences for reset during starvation and reset during an ack cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset, mem_init;
  logic        p_read, p_write, l_req, l_we;
  logic [31:0] p_addr, p_wdata, l_addr, l_wdata;
  logic [31:0] p_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        p_stall, l_ack, l_err, mem_read, mem_write;
  logic [31:0] tmem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.SIZE(1024), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_err(l_err), .l_rdata(l_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word-addressed memory with combinational read
  assign mem_rdata = tmem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 1024; k++) tmem[k] <= 32'h0;
      tmem[4] <= 32'hDEADBEEF;
    end else if (mem_write) begin
      tmem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic pr, pw; logic [31:0] pa, pd;
    logic lr, lw; logic [31:0] la, ld;
    logic es, erd, ewr; logic [31:0] ea, ed;
    logic ek, ee; logic [31:0] elr;
    logic cp; logic [31:0] epr;
  } vec_t;

  vec_t vt [0:25];

  function automatic vec_t v(input logic pr, pw, input logic [31:0] pa, pd,
                             input logic lr, lw, input logic [31:0] la, ld,
                             input logic es, erd, ewr, input logic [31:0] ea, ed,
                             input logic ek, ee, input logic [31:0] elr,
                             input logic cp, input logic [31:0] epr);
    vec_t r;
    r.pr = pr; r.pw = pw; r.pa = pa; r.pd = pd;
    r.lr = lr; r.lw = lw; r.la = la; r.ld = ld;
    r.es = es; r.erd = erd; r.ewr = ewr; r.ea = ea; r.ed = ed;
    r.ek = ek; r.ee = ee; r.elr = elr; r.cp = cp; r.epr = epr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pr, pw, input logic [31:0] pa, pd,
                       input logic lr, lw, input logic [31:0] la, ld);
    p_read = pr; p_write = pw; p_addr = pa; p_wdata = pd;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // idle pipeline read of word 4
    vt[0]  = v(1,0,32'h10,0, 0,0,0,0,            0,1,0,32'h10,0,           0,0,0,           1,32'hDEADBEEF);
    // loader write 0x20, then ack
    vt[1]  = v(0,0,0,0, 1,1,32'h20,32'h12345678, 0,0,1,32'h20,32'h12345678, 0,0,0,           0,0);
    vt[2]  = v(0,0,0,0, 1,1,32'h20,32'h12345678, 0,0,0,0,0,                 1,0,0,           0,0);
    vt[3]  = v(0,0,0,0, 0,0,0,0,                 0,0,0,0,0,                 0,0,0,           0,0);
    // loader read back 0x20
    vt[4]  = v(0,0,0,0, 1,0,32'h20,0,            0,1,0,32'h20,0,            0,0,0,           1,32'h12345678);
    vt[5]  = v(0,0,0,0, 1,0,32'h20,0,            0,0,0,0,0,                 1,0,32'h12345678,0,0);
    vt[6]  = v(0,0,0,0, 0,0,0,0,                 0,0,0,0,0,                 0,0,32'h12345678,0,0);
    // contention: four pipeline wins, then forced loader slot with stall
    for (int i = 7; i <= 10; i++)
      vt[i] = v(1,0,32'h10,0, 1,0,32'h20,0,      0,1,0,32'h10,0,            0,0,32'h12345678,1,32'hDEADBEEF);
    vt[11] = v(1,0,32'h10,0, 1,0,32'h20,0,       1,1,0,32'h20,0,            0,0,32'h12345678,1,32'h12345678);
    vt[12] = v(1,0,32'h10,0, 1,0,32'h20,0,       0,1,0,32'h10,0,            1,0,32'h12345678,1,32'hDEADBEEF);
    vt[13] = v(1,0,32'h10,0, 0,0,0,0,            0,1,0,32'h10,0,            0,0,32'h12345678,1,32'hDEADBEEF);
    // out-of-range loader write at SIZE*4: suppressed, error ack, word 0 untouched
    vt[14] = v(0,0,0,0, 1,1,32'h1000,32'hFFFFFFFF, 0,0,0,32'h1000,32'hFFFFFFFF, 0,0,32'h12345678,0,0);
    vt[15] = v(0,0,0,0, 1,1,32'h1000,32'hFFFFFFFF, 0,0,0,0,0,               1,1,0,           0,0);
    vt[16] = v(1,0,0,0, 0,0,0,0,                 0,1,0,0,0,                 0,0,0,           1,0);
    // back-to-back loader reads: ack every other cycle
    vt[17] = v(0,0,0,0, 1,0,32'h20,0,            0,1,0,32'h20,0,            0,0,0,           0,0);
    vt[18] = v(0,0,0,0, 1,0,32'h20,0,            0,0,0,0,0,                 1,0,32'h12345678,0,0);
    vt[19] = v(0,0,0,0, 1,0,32'h20,0,            0,1,0,32'h20,0,            0,0,32'h12345678,0,0);
    vt[20] = vt[18];
    vt[21] = vt[19];
    vt[22] = vt[18];
    vt[23] = v(0,0,0,0, 0,0,0,0,                 0,0,0,0,0,                 0,0,32'h12345678,0,0);
    // pipeline store then load
    vt[24] = v(0,1,32'h30,32'hA5A5A5A5, 0,0,0,0, 0,0,1,32'h30,32'hA5A5A5A5, 0,0,32'h12345678,0,0);
    vt[25] = v(1,0,32'h30,0, 0,0,0,0,            0,1,0,32'h30,0,            0,0,32'h12345678,1,32'hA5A5A5A5);

    reset = 1'b1; mem_init = 1'b1;
    drive(0,1,32'h8,32'h1, 0,0,0,0);
    @(negedge clk);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_stall", {31'h0, p_stall}, 32'h0);
    chk("rst_ack", {31'h0, l_ack}, 32'h0);
    chk("rst_err", {31'h0, l_err}, 32'h0);
    chk("rst_rdata", l_rdata, 32'h0);
    drive(0,0,0,0, 0,0,0,0);
    next_cycle();
    reset = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(vt[i].pr, vt[i].pw, vt[i].pa, vt[i].pd, vt[i].lr, vt[i].lw, vt[i].la, vt[i].ld);
      @(negedge clk);
      chk($sformatf("row%0d_stall", i), {31'h0, p_stall}, {31'h0, vt[i].es});
      chk($sformatf("row%0d_mem_read", i), {31'h0, mem_read}, {31'h0, vt[i].erd});
      chk($sformatf("row%0d_mem_write", i), {31'h0, mem_write}, {31'h0, vt[i].ewr});
      chk($sformatf("row%0d_mem_addr", i), mem_addr, vt[i].ea);
      chk($sformatf("row%0d_mem_wdata", i), mem_wdata, vt[i].ed);
      chk($sformatf("row%0d_ack", i), {31'h0, l_ack}, {31'h0, vt[i].ek});
      chk($sformatf("row%0d_err", i), {31'h0, l_err}, {31'h0, vt[i].ee});
      chk($sformatf("row%0d_l_rdata", i), l_rdata, vt[i].elr);
      if (vt[i].cp) chk($sformatf("row%0d_p_rdata", i), p_rdata, vt[i].epr);
      next_cycle();
    end

    // Starvation count must restart from zero after a reset mid-contention
    drive(1,0,32'h10,0, 1,0,32'h20,0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_stall%0d", i), {31'h0, p_stall}, 32'h0);
      next_cycle();
    end
    #1 reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_stall%0d", i), {31'h0, p_stall}, (i == 4) ? 32'h1 : 32'h0);
      next_cycle();
    end
    chk("post_rst_ack", {31'h0, l_ack}, 32'h1);
    drive(0,0,0,0, 0,0,0,0);
    next_cycle();

    // Reset asserted asynchronously during an ack cycle
    drive(0,0,0,0, 1,0,32'h20,0);
    @(negedge clk);
    chk("seq_ack_mem_read", {31'h0, mem_read}, 32'h1);
    next_cycle();
    chk("seq_ack_before_rst", {31'h0, l_ack}, 32'h1);
    #2;
    drive(0,1,32'h4C,32'h55, 1,1,32'h48,32'h99);
    reset = 1'b1;
    #1;
    chk("async_rst_ack", {31'h0, l_ack}, 32'h0);
    chk("async_rst_rdata", l_rdata, 32'h0);
    chk("async_rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("async_rst_stall", {31'h0, p_stall}, 32'h0);
    @(negedge clk);
    chk("rst_hold_mem_write", {31'h0, mem_write}, 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("rel_no_ack0", {31'h0, l_ack}, 32'h0);
    next_cycle();
    chk("rel_no_ack1", {31'h0, l_ack}, 32'h0);
    drive(1,0,32'h48,0, 0,0,0,0);
    @(negedge clk);
    chk("rst_no_loader_write", p_rdata, 32'h0);
    next_cycle();
    drive(1,0,32'h4C,0, 0,0,0,0);
    @(negedge clk);
    chk("rst_no_pipe_write", p_rdata, 32'h0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
